dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
- Initiator/controller for one DSP slice configured as a multiply-accumulator.
- Accepts a length-N stream of (a, b) operand pairs over a valid/ready handshake and drives the slice's a, b, opmode, alumode, inmode, carryinsel and clock-enable inputs.
- Tracks the slice's pipeline latency and captures the final p as one 48-bit dot-product result on a valid/ready output.
- Sits between the datapath producers and the DSP slice; it is the driving end of the slice's control and operand interface.

Parameters:
A_WIDTH, 30, width of the a operand.
B_WIDTH, 18, width of the b operand.
LEN_WIDTH, 16, width of the element-count input.
LAT, 3, cycles from a/b driven to p updated (A_REG/B_REG=1, M_REG=1, P_REG=1).
CTRL_LAT, 2, cycles from a/b driven to opmode/cep needed at the slice input (OPMODE_REG=1).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
start  in  1  begin a job; sampled only in IDLE.
len  in  LEN_WIDTH  element count, latched on an accepted start.
s_valid  in  1  operand pair valid.
s_ready  out  1  operand pair accepted when s_valid & s_ready.
s_a  in  A_WIDTH  operand a.
s_b  in  B_WIDTH  operand b.
dsp_a  out  A_WIDTH  to slice a.
dsp_b  out  B_WIDTH  to slice b.
dsp_cea2  out  1  a register enable.
dsp_ceb2  out  1  b register enable.
dsp_cem  out  1  m register enable.
dsp_cep  out  1  p register enable.
dsp_opmode  out  7  to slice opmode.
dsp_alumode  out  4  constant 4'b0000 (Z+X+Y+CIN).
dsp_inmode  out  5  constant 5'b00000.
dsp_carryinsel  out  3  constant 3'b000.
dsp_p  in  48  slice p output.
m_valid  out  1  result valid.
m_ready  in  1  result accepted when m_valid & m_ready.
m_data  out  48  accumulated result.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state IDLE; all counters and tag pipelines cleared;
  - s_ready=0, m_valid=0, m_data=0, busy=0;
  - all dsp_ce*=0, dsp_opmode=7'b0000000, dsp_a=0, dsp_b=0.
  - Reset mid-job abandons the job; no result is produced.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start=1 with len>0: latch len, clear issue count, go to FEED.
  - start=1 with len=0: m_data=0, m_valid=1 next cycle, go to DONE; the slice is not touched.
  - start while busy is ignored.
- FEED:
  - s_ready=1.
  - Each handshake drives dsp_a/dsp_b and dsp_cea2/dsp_ceb2=1 for that cycle, and pushes a valid tag and a first tag (issue count = 0) into a shift pipeline.
  - Stall cycles (s_valid=0) push tag 0 and drive cea2/ceb2=0.
  - After the len-th handshake: s_ready=0 the next cycle, go to DRAIN.
- Tag alignment:
  - dsp_cem = valid tag delayed 1 cycle.
  - dsp_cep = valid tag delayed CTRL_LAT cycles.
  - dsp_opmode is driven at the same delay: 7'h05 (X=M, Y=M, Z=0) for the first element, 7'h25 (Z=P) for later elements, 7'h00 for bubbles.
  - Bubbles hold p because cep=0.
- DRAIN:
  - Wait until the last element's tag has exited the pipeline, i.e. LAT cycles after its handshake.
  - Then register m_data=dsp_p, set m_valid=1, go to DONE.
- DONE:
  - m_valid and m_data are held until m_ready=1.
  - On the handshake: m_valid=0, go to IDLE.
  - m_ready with m_valid=0 has no effect.
- Arithmetic:
  - The product is a signed 25x18 value, sign-extended to 48 bits by the slice.
  - Accumulation wraps modulo 2^48; overflow is not detected.
- Job latency: first handshake to m_valid = (len-1 + stall cycles) + LAT + 1 cycles.

Test Plan:
- Reset then idle: rst 3 cycles -> m_valid=0, s_ready=0, busy=0, dsp_cep=0, dsp_opmode=0.
- len=4, pairs (1,2),(3,4),(5,6),(7,8) streamed back-to-back -> dsp_opmode sequence 05,25,25,25; m_data=100, m_valid 3+LAT+1=7 cycles after the first handshake.
- len=3 with s_valid low for 2 cycles between elements, pairs (-2,5),(4,-3),(10,10) -> dsp_cep pulses exactly 3 times; m_data=78.
- len=0 -> m_data=0, m_valid=1 the next cycle, no dsp_ce* asserted.
- m_ready held low 5 cycles -> m_data stable, start ignored, busy=1; the accepting cycle returns to IDLE.
- rst asserted after 2 of 5 elements -> outputs at reset values; a following len=1, pair (3,3) job gives m_data=9.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Sequencer that feeds a DSP slice configured as a multiply-accumulator.
// It streams operand pairs into the slice and returns the final P as one dot-product result.
module dsp_mac_sequencer #(
  parameter int A_WIDTH   = 30,
  parameter int B_WIDTH   = 18,
  parameter int LEN_WIDTH = 16,
  parameter int LAT       = 3,
  parameter int CTRL_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [A_WIDTH-1:0]   s_a,
  input  logic [B_WIDTH-1:0]   s_b,
  output logic [A_WIDTH-1:0]   dsp_a,
  output logic [B_WIDTH-1:0]   dsp_b,
  output logic                 dsp_cea2,
  output logic                 dsp_ceb2,
  output logic                 dsp_cem,
  output logic                 dsp_cep,
  output logic [6:0]           dsp_opmode,
  output logic [3:0]           dsp_alumode,
  output logic [4:0]           dsp_inmode,
  output logic [2:0]           dsp_carryinsel,
  input  logic [47:0]          dsp_p,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [47:0]          m_data,
  output logic                 busy
);

  localparam int         DW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [6:0] OP_FIRST = 7'h05;
  localparam logic [6:0] OP_ACC   = 7'h25;
  localparam logic [6:0] OP_NONE  = 7'h00;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [DW-1:0]        r_drain;
  logic [CTRL_LAT-1:0]  r_vtag;
  logic [CTRL_LAT-1:0]  r_ftag;
  logic [47:0]          r_m_data;
  logic                 w_fire;
  logic                 w_last;
  logic                 w_drain_done;

  assign w_fire       = (r_state == S_FEED) && s_valid;
  assign w_last       = w_fire && (r_cnt == r_len - LEN_WIDTH'(1));
  assign w_drain_done = (r_state == S_DRAIN) && (r_drain == DW'(LAT - 1));

  // NOTE: state and datapath registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = (len == '0) ? S_DONE : S_FEED;
      S_FEED:  if (w_last) w_next = S_DRAIN;
      S_DRAIN: if (w_drain_done) w_next = S_DONE;
      S_DONE:  if (m_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    busy    = 1'b1;
    unique case (r_state)
      S_IDLE:  busy    = 1'b0;
      S_FEED:  s_ready = 1'b1;
      S_DRAIN: ;
      S_DONE:  m_valid = 1'b1;
      default: busy    = 1'b0;
    endcase
  end

  // Tag pipelines: one slot per cycle, so stalls become bubbles that hold P.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len    <= '0;
      r_cnt    <= '0;
      r_drain  <= '0;
      r_vtag   <= '0;
      r_ftag   <= '0;
      r_m_data <= '0;
    end else begin
      r_vtag <= (r_vtag << 1) | CTRL_LAT'(w_fire);
      r_ftag <= (r_ftag << 1) | CTRL_LAT'(w_fire && (r_cnt == '0));
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len   <= len;
            r_cnt   <= '0;
            r_drain <= '0;
            if (len == '0) r_m_data <= '0;
          end
        end
        S_FEED:  if (w_fire) r_cnt <= r_cnt + LEN_WIDTH'(1);
        S_DRAIN: begin
          if (w_drain_done) r_m_data <= dsp_p;
          else              r_drain  <= r_drain + DW'(1);
        end
        default: ;
      endcase
    end
  end

  // Operands pass straight through in the handshake cycle; zero otherwise.
  assign dsp_a          = w_fire ? s_a : '0;
  assign dsp_b          = w_fire ? s_b : '0;
  assign dsp_cea2       = w_fire;
  assign dsp_ceb2       = w_fire;
  assign dsp_cem        = r_vtag[0];
  assign dsp_cep        = r_vtag[CTRL_LAT-1];
  assign dsp_opmode     = !r_vtag[CTRL_LAT-1] ? OP_NONE :
                          (r_ftag[CTRL_LAT-1] ? OP_FIRST : OP_ACC);
  assign dsp_alumode    = 4'b0000;
  assign dsp_inmode     = 5'b00000;
  assign dsp_carryinsel = 3'b000;
  assign m_data         = r_m_data;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a small behavioural model of the DSP slice.
module tb_dsp_mac_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic        s_valid;
  logic        s_ready;
  logic [29:0] s_a;
  logic [17:0] s_b;
  logic [29:0] dsp_a;
  logic [17:0] dsp_b;
  logic        dsp_cea2, dsp_ceb2, dsp_cem, dsp_cep;
  logic [6:0]  dsp_opmode;
  logic [3:0]  dsp_alumode;
  logic [4:0]  dsp_inmode;
  logic [2:0]  dsp_carryinsel;
  logic [47:0] dsp_p;
  logic        m_valid;
  logic        m_ready;
  logic [47:0] m_data;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [29:0] ta [8];
  logic [17:0] tbv[8];
  logic [6:0]  ops[8];

  dsp_mac_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_cea2(dsp_cea2), .dsp_ceb2(dsp_ceb2),
    .dsp_cem(dsp_cem), .dsp_cep(dsp_cep), .dsp_opmode(dsp_opmode),
    .dsp_alumode(dsp_alumode), .dsp_inmode(dsp_inmode),
    .dsp_carryinsel(dsp_carryinsel), .dsp_p(dsp_p),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice model: A/B reg, M reg, P reg; opmode takes effect alongside cep.
  logic [29:0]        sl_a = '0;
  logic [17:0]        sl_b = '0;
  logic signed [47:0] sl_m = '0;
  logic [47:0]        sl_p = '0;
  wire  signed [47:0] sl_prod = $signed(sl_a[24:0]) * $signed(sl_b);

  always @(posedge clk) begin
    if (dsp_cea2) sl_a <= dsp_a;
    if (dsp_ceb2) sl_b <= dsp_b;
    if (dsp_cem)  sl_m <= sl_prod;
    if (dsp_cep) begin
      if (dsp_opmode == 7'h05)      sl_p <= sl_m;
      else if (dsp_opmode == 7'h25) sl_p <= sl_p + sl_m;
    end
  end
  assign dsp_p = sl_p;

  // Runs one job from the tables; k=0 is the first cycle after start is taken.
  task automatic run_job(input int n, input int gap,
                         output int vcyc, output int ncep, output int nce);
    int idx = 0;
    int wait_cnt = 0;
    vcyc = -1; ncep = 0; nce = 0;
    @(posedge clk); #1;
    start = 1'b1; len = n[15:0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (idx < n && wait_cnt == 0) begin
        s_valid = 1'b1; s_a = ta[idx]; s_b = tbv[idx];
      end else begin
        s_valid = 1'b0; s_a = '0; s_b = '0;
      end
      @(negedge clk);
      if (dsp_cea2 || dsp_ceb2 || dsp_cem || dsp_cep) nce++;
      if (dsp_cep) begin
        if (ncep < 8) ops[ncep] = dsp_opmode;
        ncep++;
      end
      if (m_valid) begin
        vcyc = k;
        break;
      end
      if (s_valid && s_ready) begin
        idx++;
        wait_cnt = gap;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_a = '0; s_b = '0;
  endtask

  task automatic accept_result();
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (dsp_cep !== 1'b0) begin errors++; $display("FAIL reset_cep: got %b want 0", dsp_cep); end
    checks++; if (dsp_opmode !== 7'h00) begin errors++; $display("FAIL reset_opmode: got %h want 00", dsp_opmode); end
    checks++; if (m_data !== 48'd0) begin errors++; $display("FAIL reset_m_data: got %0d want 0", m_data); end
    checks++; if ({dsp_alumode, dsp_inmode, dsp_carryinsel} !== 12'h000) begin
      errors++; $display("FAIL const_ctrl: got %h want 000", {dsp_alumode, dsp_inmode, dsp_carryinsel});
    end
  endtask

  task automatic test_back_to_back();
    int vcyc, ncep, nce;
    ta[0] = 30'd1; tbv[0] = 18'd2;
    ta[1] = 30'd3; tbv[1] = 18'd4;
    ta[2] = 30'd5; tbv[2] = 18'd6;
    ta[3] = 30'd7; tbv[3] = 18'd8;
    run_job(4, 0, vcyc, ncep, nce);
    checks++; if (vcyc !== 7) begin errors++; $display("FAIL b2b_latency: got %0d want 7", vcyc); end
    checks++; if (m_data !== 48'd100) begin errors++; $display("FAIL b2b_m_data: got %0d want 100", m_data); end
    checks++; if (ncep !== 4) begin errors++; $display("FAIL b2b_cep_count: got %0d want 4", ncep); end
    checks++; if ({ops[0], ops[1], ops[2], ops[3]} !== {7'h05, 7'h25, 7'h25, 7'h25}) begin
      errors++; $display("FAIL b2b_opmode: got %h %h %h %h want 05 25 25 25", ops[0], ops[1], ops[2], ops[3]);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_done: got %b want 1", busy); end
    accept_result();
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_to_idle: got m_valid=%b busy=%b want 0 0", m_valid, busy);
    end
  endtask

  task automatic test_stalls();
    int vcyc, ncep, nce;
    ta[0] = -30'sd2; tbv[0] = 18'd5;
    ta[1] = 30'd4;   tbv[1] = -18'sd3;
    ta[2] = 30'd10;  tbv[2] = 18'd10;
    run_job(3, 2, vcyc, ncep, nce);
    checks++; if (ncep !== 3) begin errors++; $display("FAIL stall_cep_count: got %0d want 3", ncep); end
    checks++; if (m_data !== 48'd78) begin errors++; $display("FAIL stall_m_data: got %0d want 78", m_data); end
    checks++; if (vcyc !== 10) begin errors++; $display("FAIL stall_latency: got %0d want 10", vcyc); end
    checks++; if ({ops[0], ops[1], ops[2]} !== {7'h05, 7'h25, 7'h25}) begin
      errors++; $display("FAIL stall_opmode: got %h %h %h want 05 25 25", ops[0], ops[1], ops[2]);
    end
    accept_result();
  endtask

  task automatic test_zero_len();
    int vcyc, ncep, nce;
    run_job(0, 0, vcyc, ncep, nce);
    checks++; if (vcyc !== 0) begin errors++; $display("FAIL zero_latency: got %0d want 0", vcyc); end
    checks++; if (m_data !== 48'd0) begin errors++; $display("FAIL zero_m_data: got %0d want 0", m_data); end
    checks++; if (nce !== 0) begin errors++; $display("FAIL zero_ce_cycles: got %0d want 0", nce); end
    accept_result();
  endtask

  task automatic test_backpressure();
    int vcyc, ncep, nce;
    ta[0] = 30'd6; tbv[0] = 18'd7;
    run_job(1, 0, vcyc, ncep, nce);
    checks++; if (vcyc !== 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", vcyc); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = 1'b1; len = 16'd2;
      @(negedge clk);
      checks++; if (m_valid !== 1'b1 || m_data !== 48'd42 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d]: got m_valid=%b m_data=%0d busy=%b want 1 42 1", i, m_valid, m_data, busy);
      end
    end
    start = 1'b0;
    accept_result();
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL bp_to_idle: got m_valid=%b busy=%b s_ready=%b want 0 0 0", m_valid, busy, s_ready);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL idle_m_ready: got busy=%b m_valid=%b want 0 0", busy, m_valid);
    end
  endtask

  task automatic test_reset_mid_job();
    int vcyc, ncep, nce;
    @(posedge clk); #1;
    start = 1'b1; len = 16'd5;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; s_a = 30'd1; s_b = 18'd1;
    @(posedge clk); #1;
    s_a = 30'd2; s_b = 18'd2;
    @(posedge clk); #1;
    s_valid = 1'b0; s_a = '0; s_b = '0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_state: got busy=%b s_ready=%b m_valid=%b want 0 0 0", busy, s_ready, m_valid);
    end
    checks++; if (dsp_cem !== 1'b0 || dsp_cep !== 1'b0 || dsp_opmode !== 7'h00) begin
      errors++; $display("FAIL midrst_tags: got cem=%b cep=%b opmode=%h want 0 0 00", dsp_cem, dsp_cep, dsp_opmode);
    end
    checks++; if (m_data !== 48'd0) begin errors++; $display("FAIL midrst_m_data: got %0d want 0", m_data); end
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_result: got %b want 0", m_valid); end
    ta[0] = 30'd3; tbv[0] = 18'd3;
    run_job(1, 0, vcyc, ncep, nce);
    checks++; if (vcyc !== 4) begin errors++; $display("FAIL post_rst_latency: got %0d want 4", vcyc); end
    checks++; if (m_data !== 48'd9) begin errors++; $display("FAIL post_rst_m_data: got %0d want 9", m_data); end
    accept_result();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0;
    s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_stalls();
    test_zero_len();
    test_backpressure();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
